// File: rtl/wb_burst_sram_responder_if.sv
// Wishbone refill-bus bundle between the cache arbiter (master) and the SRAM responder (slave).
// Carries the bl/bry burst extension alongside the classic cyc/stb/ack handshake.
interface wb_burst_sram_responder_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [9:0]  wb_bl_i;
  logic        wb_bry_i;
  logic [31:0] wb_dat_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_bl_i, wb_bry_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_bl_i, wb_bry_i, wb_dat_i,
    output wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/wb_burst_sram_responder.sv
// Wishbone burst responder onto a 1-port SRAM: write ack at T+1, first read beat at T+3, then 1/cycle.
// bry low stalls pops; a 2-credit limit on buffered+in-flight reads pauses SRAM issue so nothing drops.
module wb_burst_sram_responder #(
  parameter int MEM_AW     = 9,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  wb_burst_sram_responder_if.slave    wb,
  output logic                        sram_csb0,
  output logic                        sram_web0,
  output logic [3:0]                  sram_wmask0,
  output logic [MEM_AW-1:0]           sram_addr0,
  output logic [31:0]                 sram_din0,
  input  logic [31:0]                 sram_dout0
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DRAIN} state_t;

  localparam logic [2:0] CREDITS = 3'(FIFO_DEPTH);

  state_t            r_state;
  state_t            w_next;
  logic [MEM_AW-1:0] r_addr;
  logic [MEM_AW-1:0] r_last_addr;
  logic [31:0]       r_dat;
  logic [31:0]       r_last_din;
  logic [3:0]        r_sel;
  logic [9:0]        r_beats;
  logic [9:0]        r_issued;
  logic [9:0]        r_acked;
  logic              r_inflight;
  logic [31:0]       r_fifo [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;

  logic              w_req;
  logic              w_rd_active;
  logic              w_abort;
  logic              w_ack_rd;
  logic              w_ack_wr;
  logic              w_issue;
  logic              w_push;
  logic [2:0]        w_occ;
  logic              w_unused_adr;

  assign w_unused_adr = ^{wb.wb_adr_i[31:MEM_AW+2], wb.wb_adr_i[1:0]};

  assign w_req       = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_rd_active = (r_state == S_RD) || (r_state == S_DRAIN);
  assign w_abort     = w_rd_active & ~wb.wb_cyc_i;
  assign w_ack_rd    = w_rd_active & (r_count != 2'd0) & wb.wb_bry_i & w_req;
  assign w_ack_wr    = (r_state == S_WR) & wb.wb_cyc_i;

  // Counting this cycle's pop as a freed credit is what keeps the stream bubble-free.
  assign w_occ   = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_ack_rd};
  assign w_issue = (r_state == S_RD) & wb.wb_cyc_i & (r_issued != r_beats) & (w_occ < CREDITS);
  assign w_push  = r_inflight & ~w_abort;

  assign wb.wb_ack_o = w_ack_rd | w_ack_wr;
  assign wb.wb_dat_o = w_ack_rd ? r_fifo[r_rptr] : 32'd0;

  always_comb begin
    w_next      = r_state;
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = 4'd0;
    sram_addr0  = r_last_addr;
    sram_din0   = r_last_din;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_next = wb.wb_we_i ? S_WR : S_RD;
        end
      end
      S_WR: begin
        sram_csb0   = 1'b0;
        sram_web0   = 1'b0;
        sram_wmask0 = r_sel;
        sram_addr0  = r_addr;
        sram_din0   = r_dat;
        w_next      = S_IDLE;
      end
      S_RD: begin
        if (w_issue) begin
          sram_csb0  = 1'b0;
          sram_addr0 = r_addr;
        end
        if (!wb.wb_cyc_i) begin
          w_next = S_IDLE;
        end else if ((r_issued + 10'(w_issue)) == r_beats) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!wb.wb_cyc_i || ((r_acked + 10'(w_ack_rd)) == r_beats)) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_last_addr <= '0;
      r_dat       <= 32'd0;
      r_last_din  <= 32'd0;
      r_sel       <= 4'd0;
      r_beats     <= 10'd0;
      r_issued    <= 10'd0;
      r_acked     <= 10'd0;
      r_inflight  <= 1'b0;
      r_fifo[0]   <= 32'd0;
      r_fifo[1]   <= 32'd0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      r_state     <= w_next;
      r_last_addr <= sram_addr0;
      r_last_din  <= sram_din0;
      r_inflight  <= w_issue;

      if (r_state == S_IDLE && w_req) begin
        r_addr   <= wb.wb_adr_i[MEM_AW+1:2];
        r_sel    <= wb.wb_sel_i;
        r_dat    <= wb.wb_dat_i;
        r_beats  <= (wb.wb_bl_i == 10'd0) ? 10'd1 : wb.wb_bl_i;
        r_issued <= 10'd0;
        r_acked  <= 10'd0;
      end

      if (w_issue) begin
        r_addr   <= r_addr + 1'b1;
        r_issued <= r_issued + 10'd1;
      end

      // An abort also discards the read still in the SRAM pipeline (w_push is masked).
      if (w_abort) begin
        r_count <= 2'd0;
        r_wptr  <= 1'b0;
        r_rptr  <= 1'b0;
      end else begin
        if (w_push) begin
          r_fifo[r_wptr] <= sram_dout0;
          r_wptr         <= ~r_wptr;
        end
        if (w_ack_rd) begin
          r_rptr  <= ~r_rptr;
          r_acked <= r_acked + 10'd1;
        end
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_ack_rd};
      end
    end
  end

endmodule
